// File: rtl/sram_arbiter_if.sv
// Requester and SRAM-side signal bundle for the two-port SRAM arbiter.
// The arbiter takes the slave view; the environment (requesters plus SRAM) takes the master view.
interface sram_arbiter_if #(
  parameter int ADDR_W = 16
) ();
  logic              spi_req;
  logic              spi_we;
  logic [ADDR_W-1:0] spi_addr;
  logic [7:0]        spi_wdata;
  logic              coco_req;
  logic              coco_we;
  logic [ADDR_W-1:0] coco_addr;
  logic [7:0]        coco_wdata;
  logic              spi_ack;
  logic              coco_ack;
  logic              spi_busy;
  logic              coco_busy;
  logic              spi_overrun;
  logic              coco_overrun;
  logic [7:0]        rdata;
  logic              actor;
  logic [17:0]       sram_addr;
  logic [7:0]        sram_dq_in;
  logic [7:0]        sram_dq_out;
  logic              sram_dq_oe;
  logic              sram_we_n;
  logic              sram_oe_n;
  logic              sram_ce_n;

  modport slave (
    input  spi_req, spi_we, spi_addr, spi_wdata,
    input  coco_req, coco_we, coco_addr, coco_wdata,
    input  sram_dq_in,
    output spi_ack, coco_ack, spi_busy, coco_busy, spi_overrun, coco_overrun,
    output rdata, actor,
    output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n
  );

  modport master (
    output spi_req, spi_we, spi_addr, spi_wdata,
    output coco_req, coco_we, coco_addr, coco_wdata,
    output sram_dq_in,
    input  spi_ack, coco_ack, spi_busy, coco_busy, spi_overrun, coco_overrun,
    input  rdata, actor,
    input  sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port (SPI / Coco) arbiter for an asynchronous SRAM: each port holds one pending
// request, grants alternate fairly under contention, every access takes ACCESS_CYCLES clocks.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 6,
  parameter int ADDR_W        = 16
) (
  input  logic          clock_50,
  input  logic          reset,
  sram_arbiter_if.slave bus
);
  localparam int P_COCO = 0;
  localparam int P_SPI  = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [2:0]        cnt_reg, cnt_next;
  logic              gnt_spi_reg, gnt_spi_next;
  logic              fair_reg, fair_next;
  logic              sel_spi;

  logic [1:0]        req_in;
  logic [1:0]        we_in;
  logic [ADDR_W-1:0] addr_in [2];
  logic [7:0]        wdata_in [2];

  logic [1:0]        pend_reg;
  logic [1:0]        pend_we_reg;
  logic [ADDR_W-1:0] pend_addr_reg [2];
  logic [7:0]        pend_wdata_reg [2];
  logic [1:0]        ovr_reg;
  logic [7:0]        rdata_reg;

  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [7:0]        g_wdata;

  assign req_in            = {bus.spi_req, bus.coco_req};
  assign we_in             = {bus.spi_we, bus.coco_we};
  assign addr_in[P_SPI]    = bus.spi_addr;
  assign addr_in[P_COCO]   = bus.coco_addr;
  assign wdata_in[P_SPI]   = bus.spi_wdata;
  assign wdata_in[P_COCO]  = bus.coco_wdata;

  // Per-port pending slot: a request is only taken while the slot is empty, and the slot
  // stays occupied through the port's DONE cycle, so a req there counts as an overrun.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      localparam logic IS_SPI = (gi == P_SPI);
      logic clr;
      assign clr = (state_reg == DONE) && (gnt_spi_reg == IS_SPI);

      always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
          pend_reg[gi]       <= 1'b0;
          pend_we_reg[gi]    <= 1'b0;
          pend_addr_reg[gi]  <= '0;
          pend_wdata_reg[gi] <= 8'h00;
          ovr_reg[gi]        <= 1'b0;
        end else begin
          if (req_in[gi] && !pend_reg[gi]) begin
            pend_reg[gi]       <= 1'b1;
            pend_we_reg[gi]    <= we_in[gi];
            pend_addr_reg[gi]  <= addr_in[gi];
            pend_wdata_reg[gi] <= wdata_in[gi];
          end else if (clr) begin
            pend_reg[gi] <= 1'b0;
          end
          if (req_in[gi] && pend_reg[gi]) begin
            ovr_reg[gi] <= 1'b1;
          end
        end
      end
    end
  endgenerate

  assign g_we    = pend_we_reg[gnt_spi_reg];
  assign g_addr  = pend_addr_reg[gnt_spi_reg];
  assign g_wdata = pend_wdata_reg[gnt_spi_reg];
  assign sel_spi = pend_reg[P_SPI] && !(pend_reg[P_COCO] && fair_reg);

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= 3'd0;
      gnt_spi_reg <= 1'b0;
      fair_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      gnt_spi_reg <= gnt_spi_next;
      fair_reg    <= fair_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    gnt_spi_next = gnt_spi_reg;
    fair_next    = fair_reg;
    case (state_reg)
      IDLE: begin
        if (|pend_reg) begin
          gnt_spi_next = sel_spi;
          cnt_next     = 3'(ACCESS_CYCLES - 1);
          state_next   = ACCESS;
          if (sel_spi && pend_reg[P_COCO]) begin
            fair_next = 1'b1;
          end else if (!sel_spi) begin
            fair_next = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (cnt_reg == 3'd0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 3'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write strobe is released on the last ACCESS cycle so address and data are held past it.
  always_comb begin
    bus.sram_we_n   = 1'b1;
    bus.sram_dq_oe  = 1'b0;
    bus.sram_addr   = 18'h00000;
    bus.actor       = 1'b0;
    bus.spi_ack     = 1'b0;
    bus.coco_ack    = 1'b0;
    if (state_reg == ACCESS) begin
      bus.sram_dq_oe = g_we;
      bus.sram_we_n  = !(g_we && (cnt_reg != 3'd0));
    end
    if (state_reg != IDLE) begin
      bus.sram_addr = 18'(g_addr);
      bus.actor     = gnt_spi_reg;
    end
    if (state_reg == DONE) begin
      bus.spi_ack  = gnt_spi_reg;
      bus.coco_ack = !gnt_spi_reg;
    end
  end

  assign bus.sram_oe_n   = ~bus.sram_we_n;
  assign bus.sram_ce_n   = 1'b0;
  assign bus.sram_dq_out = g_wdata;

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      rdata_reg <= 8'h00;
    end else if ((state_reg == ACCESS) && (cnt_reg == 3'd0) && !g_we) begin
      rdata_reg <= bus.sram_dq_in;
    end
  end

  assign bus.rdata        = rdata_reg;
  assign bus.spi_busy     = pend_reg[P_SPI];
  assign bus.coco_busy    = pend_reg[P_COCO];
  assign bus.spi_overrun  = ovr_reg[P_SPI];
  assign bus.coco_overrun = ovr_reg[P_COCO];
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and random checks of sram_arbiter against a behavioural SRAM and a reference memory.
module tb_sram_arbiter;
  localparam int AC = 6;
  localparam int AW = 16;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } txn_t;

  logic       clock_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       mem_clr  = 1'b1;
  int         checks   = 0;
  int         errors   = 0;
  int         served   = 0;
  logic [7:0] mem [0:255];
  logic [7:0] ref_mem [0:31];
  txn_t       q_spi [$];
  txn_t       q_coco [$];

  sram_arbiter_if #(.ADDR_W(AW)) bus ();

  sram_arbiter #(.ACCESS_CYCLES(AC), .ADDR_W(AW)) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .bus      (bus)
  );

  initial forever #10 clock_50 = ~clock_50;

  always @(posedge clock_50) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (bus.sram_we_n === 1'b0) begin
      mem[bus.sram_addr[7:0]] <= bus.sram_dq_out;
    end
  end
  assign bus.sram_dq_in = mem[bus.sram_addr[7:0]];

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_spi(input logic we, input logic [AW-1:0] addr, input logic [7:0] data);
    bus.spi_req = 1'b1; bus.spi_we = we; bus.spi_addr = addr; bus.spi_wdata = data;
  endtask

  task automatic drive_coco(input logic we, input logic [AW-1:0] addr, input logic [7:0] data);
    bus.coco_req = 1'b1; bus.coco_we = we; bus.coco_addr = addr; bus.coco_wdata = data;
  endtask

  task automatic wait_ack(input bit is_spi, input int max_cyc, output int n);
    n = -1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clock_50);
      bus.spi_req = 1'b0; bus.coco_req = 1'b0;
      if ((is_spi ? bus.spi_ack : bus.coco_ack) === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic service(input bit is_spi);
    txn_t t;
    int   sz;
    sz = is_spi ? q_spi.size() : q_coco.size();
    chk(is_spi ? "rnd_spi_expected" : "rnd_coco_expected", 32'(sz > 0), 32'd1);
    if (sz > 0) begin
      t = is_spi ? q_spi.pop_front() : q_coco.pop_front();
      served++;
      chk("rnd_addr", 32'(bus.sram_addr), 32'({2'b00, t.addr}));
      chk("rnd_actor", 32'(bus.actor), 32'(is_spi));
      if (t.we) ref_mem[t.addr[4:0]] = t.data;
      else chk("rnd_rdata", 32'(bus.rdata), 32'(ref_mem[t.addr[4:0]]));
      $display("txn %0d port=%s we=%0d addr=%04h data=%02h rdata=%02h", served,
               is_spi ? "spi" : "coco", t.we, t.addr, t.data, bus.rdata);
    end
  endtask

  initial begin
    int   n, we_low, ack_k, ack_cnt, cnt_a, cnt_b, issued;
    int   order [$];
    bit   spi_again;
    txn_t t;

    bus.spi_req = 1'b0;  bus.spi_we = 1'b0;  bus.spi_addr = '0;  bus.spi_wdata = 8'h00;
    bus.coco_req = 1'b0; bus.coco_we = 1'b0; bus.coco_addr = '0; bus.coco_wdata = 8'h00;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
    repeat (3) @(negedge clock_50);

    // Reset state
    chk("rst_spi_ack", 32'(bus.spi_ack), 0);
    chk("rst_coco_ack", 32'(bus.coco_ack), 0);
    chk("rst_spi_busy", 32'(bus.spi_busy), 0);
    chk("rst_coco_busy", 32'(bus.coco_busy), 0);
    chk("rst_spi_ovr", 32'(bus.spi_overrun), 0);
    chk("rst_coco_ovr", 32'(bus.coco_overrun), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_actor", 32'(bus.actor), 0);
    chk("rst_we_n", 32'(bus.sram_we_n), 1);
    chk("rst_dq_oe", 32'(bus.sram_dq_oe), 0);
    chk("rst_addr", 32'(bus.sram_addr), 0);
    chk("rst_ce_n", 32'(bus.sram_ce_n), 0);
    reset = 1'b0; mem_clr = 1'b0;
    @(negedge clock_50);

    // SPI write 0x1234 <= 0xA5 on an idle block
    drive_spi(1'b1, 16'h1234, 8'hA5);
    we_low = 0; ack_k = -1; ack_cnt = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock_50);
      bus.spi_req = 1'b0;
      if (bus.sram_we_n === 1'b0) we_low++;
      if (bus.spi_ack === 1'b1) begin
        ack_cnt++;
        if (ack_k < 0) ack_k = k;
        chk("w_ack_actor", 32'(bus.actor), 1);
      end
      if (k == 1) chk("w_busy", 32'(bus.spi_busy), 1);
      if (k == 3) begin
        chk("w_addr", 32'(bus.sram_addr), 32'h01234);
        chk("w_actor", 32'(bus.actor), 1);
        chk("w_dq_oe", 32'(bus.sram_dq_oe), 1);
        chk("w_dq_out", 32'(bus.sram_dq_out), 32'hA5);
        chk("w_oe_n", 32'(bus.sram_oe_n), 1);
      end
      if (k == 7) begin
        chk("w_last_we_n", 32'(bus.sram_we_n), 1);
        chk("w_last_dq_oe", 32'(bus.sram_dq_oe), 1);
      end
    end
    chk("w_latency", 32'(ack_k), 32'(AC + 2));
    chk("w_we_low", 32'(we_low), 32'(AC - 1));
    chk("w_ack_once", 32'(ack_cnt), 1);
    chk("w_mem", 32'(mem[8'h34]), 32'hA5);

    // Coco read-back of 0x1234
    drive_coco(1'b0, 16'h1234, 8'h00);
    we_low = 0; ack_k = -1; cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock_50);
      bus.coco_req = 1'b0;
      if (bus.sram_we_n === 1'b0) we_low++;
      if (bus.actor !== 1'b0) cnt_a++;
      if (bus.sram_dq_oe !== 1'b0) cnt_b++;
      if (bus.coco_ack === 1'b1 && ack_k < 0) begin
        ack_k = k;
        chk("r_rdata", 32'(bus.rdata), 32'hA5);
      end
    end
    chk("r_latency", 32'(ack_k), 32'(AC + 2));
    chk("r_we_low", 32'(we_low), 0);
    chk("r_actor", 32'(cnt_a), 0);
    chk("r_dq_oe", 32'(cnt_b), 0);
    repeat (3) @(negedge clock_50);
    chk("r_hold", 32'(bus.rdata), 32'hA5);

    // Simultaneous requests, SPI re-requests as soon as it is free
    drive_spi(1'b0, 16'h1234, 8'h00);
    drive_coco(1'b0, 16'h1234, 8'h00);
    spi_again = 1'b0;
    for (int k = 1; k <= 80 && order.size() < 3; k++) begin
      @(negedge clock_50);
      bus.spi_req = 1'b0; bus.coco_req = 1'b0;
      if (k == 2) begin
        chk("s_fair_set", 32'(dut.fair_reg), 1);
        chk("s_first_actor", 32'(bus.actor), 1);
      end
      if (bus.spi_ack === 1'b1 || bus.coco_ack === 1'b1)
        chk("s_dual_ack", 32'(bus.spi_ack & bus.coco_ack), 0);
      if (bus.spi_ack === 1'b1) order.push_back(1);
      if (bus.coco_ack === 1'b1) begin
        order.push_back(0);
        chk("s_fair_clr", 32'(dut.fair_reg), 0);
      end
      if (!spi_again && order.size() > 0 && bus.spi_busy === 1'b0) begin
        drive_spi(1'b0, 16'h1234, 8'h00);
        spi_again = 1'b1;
      end
    end
    chk("s_order_len", 32'(order.size()), 3);
    if (order.size() == 3) begin
      chk("s_order0", 32'(order[0]), 1);
      chk("s_order1", 32'(order[1]), 0);
      chk("s_order2", 32'(order[2]), 1);
    end
    chk("s_spi_ovr", 32'(bus.spi_overrun), 0);

    // Coco overrun while busy
    drive_coco(1'b1, 16'h0055, 8'h3C);
    @(negedge clock_50);
    bus.coco_req = 1'b0;
    chk("o_busy", 32'(bus.coco_busy), 1);
    drive_coco(1'b1, 16'h0077, 8'hEE);
    @(negedge clock_50);
    bus.coco_req = 1'b0;
    chk("o_flag", 32'(bus.coco_overrun), 1);
    wait_ack(1'b0, 20, n);
    chk("o_ack_seen", 32'(n > 0), 1);
    chk("o_addr", 32'(bus.sram_addr), 32'h00055);
    ack_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock_50);
      if (bus.coco_ack === 1'b1) ack_cnt++;
    end
    chk("o_no_extra", 32'(ack_cnt), 0);
    chk("o_mem_first", 32'(mem[8'h55]), 32'h3C);
    chk("o_mem_dropped", 32'(mem[8'h77]), 0);
    chk("o_idle_busy", 32'(bus.coco_busy), 0);
    chk("o_sticky", 32'(bus.coco_overrun), 1);

    // SPI req in its own DONE cycle is dropped, next cycle accepted
    drive_spi(1'b0, 16'h0055, 8'h00);
    wait_ack(1'b1, 20, n);
    chk("d_latency", 32'(n), 32'(AC + 2));
    chk("d_rdata", 32'(bus.rdata), 32'h3C);
    drive_spi(1'b1, 16'h0066, 8'h11);
    @(negedge clock_50);
    bus.spi_req = 1'b0;
    chk("d_ovr", 32'(bus.spi_overrun), 1);
    chk("d_dropped", 32'(bus.spi_busy), 0);
    drive_spi(1'b1, 16'h0066, 8'h11);
    @(negedge clock_50);
    bus.spi_req = 1'b0;
    chk("d_accept", 32'(bus.spi_busy), 1);
    wait_ack(1'b1, 20, n);
    chk("d_ack", 32'(n), 32'(AC + 1));
    @(negedge clock_50);
    chk("d_mem", 32'(mem[8'h66]), 32'h11);

    // Reset during the third ACCESS clock of a write
    drive_spi(1'b1, 16'h0040, 8'h99);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock_50);
      bus.spi_req = 1'b0;
    end
    chk("x_we_low", 32'(bus.sram_we_n), 0);
    #3 reset = 1'b1;
    #1;
    chk("x_we_rel", 32'(bus.sram_we_n), 1);
    chk("x_dq_oe", 32'(bus.sram_dq_oe), 0);
    chk("x_addr", 32'(bus.sram_addr), 0);
    chk("x_ack", 32'(bus.spi_ack), 0);
    @(negedge clock_50);
    @(negedge clock_50);
    reset = 1'b0;
    ack_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock_50);
      if (bus.spi_ack === 1'b1 || bus.coco_ack === 1'b1) ack_cnt++;
    end
    chk("x_no_ack", 32'(ack_cnt), 0);
    chk("x_spi_busy", 32'(bus.spi_busy), 0);
    chk("x_coco_busy", 32'(bus.coco_busy), 0);
    chk("x_coco_ovr", 32'(bus.coco_overrun), 0);
    chk("x_spi_ovr", 32'(bus.spi_overrun), 0);

    // 100 random interleaved requests
    issued = 0;
    for (int cyc = 0; cyc < 3000 && (issued < 100 || q_spi.size() > 0 || q_coco.size() > 0); cyc++) begin
      @(negedge clock_50);
      if (bus.spi_ack === 1'b1 || bus.coco_ack === 1'b1)
        chk("rnd_dual_ack", 32'(bus.spi_ack & bus.coco_ack), 0);
      if (bus.spi_ack === 1'b1) service(1'b1);
      if (bus.coco_ack === 1'b1) service(1'b0);
      bus.spi_req = 1'b0; bus.coco_req = 1'b0;
      if (issued < 100 && bus.spi_busy === 1'b0 && $urandom_range(0, 2) == 0) begin
        t.we = 1'($urandom_range(0, 1)); t.addr = AW'($urandom_range(0, 31)); t.data = 8'($urandom);
        drive_spi(t.we, t.addr, t.data);
        q_spi.push_back(t);
        issued++;
      end
      if (issued < 100 && bus.coco_busy === 1'b0 && $urandom_range(0, 2) == 0) begin
        t.we = 1'($urandom_range(0, 1)); t.addr = AW'($urandom_range(0, 31)); t.data = 8'($urandom);
        drive_coco(t.we, t.addr, t.data);
        q_coco.push_back(t);
        issued++;
      end
    end
    chk("rnd_issued", 32'(issued), 100);
    chk("rnd_served", 32'(served), 100);
    chk("rnd_drained", 32'(q_spi.size() + q_coco.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
